// File: rtl/adc_dac_sequencer_pkg.sv
// Shared types and default sizing for the ADC/DAC conversion sequencer.
package adc_dac_pkg;

   localparam int unsigned DATA_W_DEF = 10;
   localparam int unsigned NUM_CH_DEF = 4;
   localparam int unsigned CH_W_DEF   = $clog2(NUM_CH_DEF);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_TICK,
      START,
      CONVERT,
      STORE
   } seq_state_t;

endpackage

// File: rtl/adc_dac_sequencer_if.sv
// ADC conversion handshake between the sequencer (master) and the converter (slave).
interface adc_dac_sequencer_if #(
   parameter int unsigned DATA_W = 10,
   parameter int unsigned CH_W   = 2
);
   logic              adc_start;
   logic [CH_W-1:0]   adc_ch;
   logic              adc_done;
   logic [DATA_W-1:0] adc_data;

   modport master (output adc_start, adc_ch, input adc_done, adc_data);
   modport slave  (input adc_start, adc_ch, output adc_done, adc_data);
endinterface

// File: rtl/adc_dac_sequencer_rr_channel_pick.sv
// Round-robin picker: first enabled channel strictly after last_ch, wrapping.
module rr_channel_pick
   import adc_dac_pkg::*;
#(
   parameter int unsigned NUM_CH = NUM_CH_DEF,
   localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic [CH_W-1:0]   last_ch,
   output logic [CH_W-1:0]   next_ch,
   output logic              any_en
);

   int unsigned idx;

   // Scan offsets from farthest to nearest so the nearest enabled channel wins.
   always_comb begin
      next_ch = '0;
      idx     = 0;
      any_en  = |ch_mask;
      for (int unsigned k = NUM_CH; k >= 1; k--) begin
         idx = (32'(last_ch) + k) % NUM_CH;
         if (ch_mask[idx]) next_ch = CH_W'(idx);
      end
   end

endmodule

// File: rtl/adc_dac_sequencer.sv
// Multi-channel conversion scheduler: tick divider, round-robin ADC sequencing,
// per-channel sample store, DAC playback load and sticky protocol error flags.
module adc_dac_sequencer
   import adc_dac_pkg::*;
#(
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned NUM_CH       = NUM_CH_DEF,
   parameter int unsigned DIV_W        = 16,
   parameter int unsigned CONV_TIMEOUT = 64,
   localparam int unsigned CH_W        = $clog2(NUM_CH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [NUM_CH-1:0]   ch_mask,
   input  logic [DIV_W-1:0]    sample_div,
   input  logic [CH_W-1:0]     dac_sel,
   input  logic                err_clr,
   adc_dac_sequencer_if.master adc,
   output logic                sample_valid,
   output logic [CH_W-1:0]     sample_ch,
   output logic [DATA_W-1:0]   sample_data,
   output logic                dac_load,
   output logic [DATA_W-1:0]   dac_data,
   output logic                overrun,
   output logic                timeout_err
);

   localparam int unsigned TMR_W = $clog2(CONV_TIMEOUT + 1);

   seq_state_t        state, state_nxt;
   logic [DIV_W-1:0]  div_cnt;
   logic [TMR_W-1:0]  timer;
   logic [CH_W-1:0]   last_ch;
   logic [CH_W-1:0]   pick_ch;
   logic              any_en;
   logic              tick;
   logic              busy;
   logic              conv_done;
   logic              conv_abort;
   logic [DATA_W-1:0] samples [NUM_CH];

   rr_channel_pick #(.NUM_CH(NUM_CH)) u_pick (
      .ch_mask (ch_mask),
      .last_ch (last_ch),
      .next_ch (pick_ch),
      .any_en  (any_en)
   );

   assign tick       = enable && (div_cnt == sample_div);
   assign busy       = (state == START) || (state == CONVERT) || (state == STORE);
   assign conv_done  = (state == CONVERT) && adc.adc_done;
   assign conv_abort = (state == CONVERT) && !adc.adc_done
                       && (timer == TMR_W'(CONV_TIMEOUT - 1));
   assign sample_data = samples[sample_ch];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (enable) state_nxt = WAIT_TICK;
         WAIT_TICK: begin
            if (!enable)              state_nxt = IDLE;
            else if (tick && any_en)  state_nxt = START;
         end
         START:     state_nxt = CONVERT;
         CONVERT: begin
            if (conv_done)       state_nxt = STORE;
            else if (conv_abort) state_nxt = enable ? WAIT_TICK : IDLE;
         end
         STORE:     state_nxt = enable ? WAIT_TICK : IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                   div_cnt <= '0;
      else if (!enable || tick)   div_cnt <= '0;
      else                        div_cnt <= div_cnt + DIV_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  timer <= '0;
      else if (state == CONVERT) timer <= timer + TMR_W'(1);
      else                       timer <= '0;
   end

   // adc_ch doubles as the picked-channel register, so it is stable from START on.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         adc.adc_start <= 1'b0;
         adc.adc_ch    <= '0;
         last_ch       <= CH_W'(NUM_CH - 1);
      end else begin
         adc.adc_start <= (state_nxt == START);
         if (state == WAIT_TICK && state_nxt == START) adc.adc_ch <= pick_ch;
         if (state == START) last_ch <= adc.adc_ch;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sample_valid <= 1'b0;
         sample_ch    <= '0;
         dac_load     <= 1'b0;
         dac_data     <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) samples[i] <= '0;
      end else begin
         sample_valid <= conv_done;
         dac_load     <= conv_done && (adc.adc_ch == dac_sel);
         if (conv_done) begin
            samples[adc.adc_ch] <= adc.adc_data;
            sample_ch           <= adc.adc_ch;
            if (adc.adc_ch == dac_sel) dac_data <= adc.adc_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (tick && busy)  overrun <= 1'b1;
         else if (err_clr)  overrun <= 1'b0;
         if (conv_abort)    timeout_err <= 1'b1;
         else if (err_clr)  timeout_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adc_dac_sequencer.sv
// Directed self-checking bench for adc_dac_sequencer with a latency-programmable ADC model.
module tb_adc_dac_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enable = 1'b0;
   logic [3:0] ch_mask = '0;
   logic [15:0] sample_div = '0;
   logic [1:0] dac_sel = '0;
   logic       err_clr = 1'b0;
   logic       sample_valid;
   logic [1:0] sample_ch;
   logic [9:0] sample_data;
   logic       dac_load;
   logic [9:0] dac_data;
   logic       overrun;
   logic       timeout_err;

   int checks = 0;
   int failures = 0;

   adc_dac_sequencer_if #(.DATA_W(10), .CH_W(2)) adc_if ();

   adc_dac_sequencer #(.DATA_W(10), .NUM_CH(4), .DIV_W(16), .CONV_TIMEOUT(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .ch_mask      (ch_mask),
      .sample_div   (sample_div),
      .dac_sel      (dac_sel),
      .err_clr      (err_clr),
      .adc          (adc_if.master),
      .sample_valid (sample_valid),
      .sample_ch    (sample_ch),
      .sample_data  (sample_data),
      .dac_load     (dac_load),
      .dac_data     (dac_data),
      .overrun      (overrun),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   // ADC model: done arrives adc_lat cycles after the adc_start cycle; 0 means never.
   int adc_lat = 3;
   int adc_cnt = -1;
   logic [1:0] pend_ch = '0;
   initial begin
      adc_if.adc_done = 1'b0;
      adc_if.adc_data = '0;
   end
   always @(negedge clk) begin
      adc_if.adc_done = 1'b0;
      if (!rst) begin
         adc_cnt = -1;
      end else if (adc_if.adc_start) begin
         adc_cnt = (adc_lat == 0) ? -1 : adc_lat;
         pend_ch = adc_if.adc_ch;
      end else if (adc_cnt > 0) begin
         adc_cnt--;
         if (adc_cnt == 0) begin
            adc_if.adc_done = 1'b1;
            adc_if.adc_data = 10'(32'(pend_ch) * 100);
            adc_cnt = -1;
         end
      end
   end

   // Event monitor: values present during the cycle ending at this edge.
   int start_cnt = 0;
   int valid_cnt = 0;
   int dac_cnt = 0;
   int vch_log[$];
   int vdata_log[$];
   always @(posedge clk) begin
      if (adc_if.adc_start) start_cnt++;
      if (dac_load) dac_cnt++;
      if (sample_valid) begin
         valid_cnt++;
         vch_log.push_back(32'(sample_ch));
         vdata_log.push_back(32'(sample_data));
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // which: 0 = adc_start, 1 = sample_valid; n = negedges waited until seen.
   task automatic wait_evt(input int which, input int budget, input string tag, output int n);
      bit hit;
      hit = 1'b0;
      n = 0;
      while (!hit && n < budget) begin
         @(negedge clk);
         n++;
         hit = (which == 0) ? adc_if.adc_start : sample_valid;
      end
      checks++;
      assert (hit) else begin
         failures++;
         $error("FAIL %s observed=no_event expected=event_within_%0d_cycles", tag, budget);
      end
   endtask

   initial begin
      int n;
      int bs, bv, bd;
      int exp_ch[5];
      int exp_d[5];

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_adc_start", 32'(adc_if.adc_start), 0);
      check("rst_adc_ch", 32'(adc_if.adc_ch), 0);
      check("rst_sample_valid", 32'(sample_valid), 0);
      check("rst_dac_data", 32'(dac_data), 0);
      check("rst_flags", 32'({overrun, timeout_err}), 0);
      rst = 1'b1;
      @(negedge clk);

      // Round-robin over all channels, period 10
      ch_mask = 4'b1111; sample_div = 16'd9; dac_sel = 2'd0; adc_lat = 3;
      bv = valid_cnt; bd = dac_cnt;
      enable = 1'b1;
      wait_evt(0, 30, "t1_first_start", n);
      check("t1_first_latency", 32'(n), 10);
      check("t1_ch0", 32'(adc_if.adc_ch), 0);
      for (int i = 1; i <= 4; i++) begin
         wait_evt(0, 30, "t1_start", n);
         check("t1_period", 32'(n), 10);
         check("t1_ch_seq", 32'(adc_if.adc_ch), 32'(i % 4));
      end
      check("t1_valid_count", 32'(valid_cnt - bv), 4);
      check("t1_data_ch1", 32'(vdata_log[bv + 1]), 100);
      check("t1_data_ch3", 32'(vdata_log[bv + 3]), 300);
      check("t1_dac_count", 32'(dac_cnt - bd), 1);
      check("t1_flags", 32'({overrun, timeout_err}), 0);
      enable = 1'b0;
      repeat (20) @(negedge clk);

      // Masked channels 0/2, DAC on ch2, then enable drop one cycle after start
      ch_mask = 4'b0101; dac_sel = 2'd2;
      bs = start_cnt; bv = valid_cnt; bd = dac_cnt;
      exp_ch = '{2, 0, 2, 0, 2};
      exp_d  = '{200, 0, 200, 0, 200};
      enable = 1'b1;
      for (int i = 0; i < 4; i++) wait_evt(1, 30, "t2_valid", n);
      wait_evt(0, 30, "t2_fifth_start", n);
      @(negedge clk);
      enable = 1'b0;
      repeat (30) @(negedge clk);
      check("t2_start_count", 32'(start_cnt - bs), 5);
      check("t2_valid_count", 32'(valid_cnt - bv), 5);
      for (int i = 0; i < 5; i++) begin
         check("t2_store_ch", 32'(vch_log[bv + i]), 32'(exp_ch[i]));
         check("t2_store_data", 32'(vdata_log[bv + i]), 32'(exp_d[i]));
      end
      check("t2_dac_count", 32'(dac_cnt - bd), 3);
      check("t2_dac_data", 32'(dac_data), 200);

      // Overrun: tick period 3, ADC latency 5
      ch_mask = 4'b1111; sample_div = 16'd2; adc_lat = 5;
      enable = 1'b1;
      wait_evt(1, 30, "t3_first_valid", n);
      check("t3_first_ch", 32'(sample_ch), 3);
      check("t3_overrun_set", 32'(overrun), 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("t3_overrun_cleared", 32'(overrun), 0);
      repeat (2) @(negedge clk);
      check("t3_overrun_still_clear", 32'(overrun), 0);
      repeat (3) @(negedge clk);
      check("t3_overrun_reset", 32'(overrun), 1);
      enable = 1'b0;
      repeat (20) @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("t3_idle_clear", 32'({overrun, timeout_err}), 0);

      // Timeout: ADC never answers
      sample_div = 16'd99; adc_lat = 0;
      bv = valid_cnt;
      enable = 1'b1;
      wait_evt(0, 150, "t4_start", n);
      check("t4_ch", 32'(adc_if.adc_ch), 1);
      repeat (10) @(negedge clk);
      adc_lat = 3;
      repeat (54) @(negedge clk);
      check("t4_no_timeout_yet", 32'(timeout_err), 0);
      check("t4_ch_held", 32'(adc_if.adc_ch), 1);
      @(negedge clk);
      check("t4_timeout_set", 32'(timeout_err), 1);
      check("t4_no_valid", 32'(valid_cnt - bv), 0);
      wait_evt(0, 60, "t4_next_start", n);
      check("t4_next_delay", 32'(n), 35);
      check("t4_next_ch", 32'(adc_if.adc_ch), 2);
      @(negedge clk);
      check("t4_pre_rst_dac", 32'(dac_data), 200);

      // Asynchronous reset mid-CONVERT
      rst = 1'b0;
      #1;
      check("t5_adc_ch", 32'(adc_if.adc_ch), 0);
      check("t5_adc_start", 32'(adc_if.adc_start), 0);
      check("t5_flags", 32'({overrun, timeout_err}), 0);
      check("t5_dac_data", 32'(dac_data), 0);
      check("t5_sample", 32'({sample_valid, dac_load, sample_ch, sample_data}), 0);
      sample_div = 16'd4;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      wait_evt(0, 50, "t5_restart", n);
      check("t5_restart_ch", 32'(adc_if.adc_ch), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
